// File: rtl/axi4_stream_sink_pkg.sv
// Shared types and helpers for the AXI4-Stream sink: ready policies, ready FSM
// states, LFSR constants and a popcount helper for TKEEP byte counting.
package axi4_stream_sink_pkg;

    // Run-time selectable TREADY policy (3-bit encoding seen on cfg_policy).
    typedef enum logic [2:0] {
        POL_SINGLE             = 3'd0,
        POL_EVENTS             = 3'd1,
        POL_OSC                = 3'd2,
        POL_RANDOM             = 3'd3,
        POL_AFTER_VALID_SINGLE = 3'd4,
        POL_AFTER_VALID_EVENTS = 3'd5,
        POL_AFTER_VALID_OSC    = 3'd6,
        POL_ALWAYS             = 3'd7
    } policy_t;

    // Ready generator FSM states.
    typedef enum logic [1:0] {
        WAIT_VALID = 2'd0,
        LOW        = 2'd1,
        HIGH       = 2'd2
    } state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11. The register shifts right, so
    // those taps land on bits 0,2,3,5 of the current value.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Number of set bits; callers zero-extend TKEEP (up to 128 lanes).
    function automatic logic [7:0] popcount(input logic [127:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 128; i++) begin
            n = n + 8'(v[i]);
        end
        return n;
    endfunction

    // State the FSM starts in after reset or a configuration load.
    function automatic state_t init_state(input policy_t p);
        if (p == POL_AFTER_VALID_SINGLE || p == POL_AFTER_VALID_EVENTS ||
            p == POL_AFTER_VALID_OSC) begin
            return WAIT_VALID;
        end
        return LOW;
    endfunction

endpackage

// File: rtl/axi4_stream_ready_gen.sv
// TREADY generator: WAIT_VALID/LOW/HIGH FSM with a shared cycle/event counter
// and a free-running LFSR for the RANDOM policy. TREADY is a register whose
// next value is derived from the current state and the current handshake.
module axi4_stream_ready_gen
    import axi4_stream_sink_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          tvalid,
    input  logic          handshake,
    input  logic [2:0]    policy,
    input  logic [CW-1:0] low,
    input  logic [CW-1:0] high,
    input  logic [CW-1:0] events,
    output logic          tready
);

    policy_t       pol;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          tready_nxt;
    logic [15:0]   lfsr, lfsr_nxt;
    logic          after_valid;
    logic [CW-1:0] high_eff, events_eff;
    state_t        low_entry, exit_target;

    assign pol         = policy_t'(policy);
    assign after_valid = (init_state(pol) == WAIT_VALID);
    assign high_eff    = (high == '0) ? CW'(1) : high;
    assign events_eff  = (events == '0) ? CW'(1) : events;
    // A zero low time skips LOW entirely and goes straight back to HIGH.
    assign low_entry   = (low == '0) ? HIGH : LOW;
    assign exit_target = after_valid ? WAIT_VALID : low_entry;
    assign lfsr_nxt    = {^(lfsr & LFSR_TAPS), lfsr[15:1]};

    // Next-state, next-counter and next-TREADY decode.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        tready_nxt = tready;
        case (state)
            WAIT_VALID: begin
                if (tvalid) begin
                    state_nxt = low_entry;
                    cnt_nxt   = '0;
                end
            end
            LOW: begin
                if (low == '0 || cnt == low - CW'(1)) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HIGH: begin
                case (pol)
                    POL_SINGLE, POL_AFTER_VALID_SINGLE: begin
                        if (handshake) begin
                            state_nxt = exit_target;
                            cnt_nxt   = '0;
                        end
                    end
                    POL_EVENTS, POL_AFTER_VALID_EVENTS: begin
                        if (handshake) begin
                            if (cnt == events_eff - CW'(1)) begin
                                state_nxt = exit_target;
                                cnt_nxt   = '0;
                            end else begin
                                cnt_nxt = cnt + CW'(1);
                            end
                        end
                    end
                    POL_OSC, POL_AFTER_VALID_OSC: begin
                        if (cnt == high_eff - CW'(1)) begin
                            state_nxt = exit_target;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                state_nxt = init_state(pol);
                cnt_nxt   = '0;
            end
        endcase
        tready_nxt = (state_nxt == HIGH);
        if (pol == POL_RANDOM) begin
            tready_nxt = lfsr_nxt[0];
        end else if (pol == POL_ALWAYS) begin
            tready_nxt = 1'b1;
        end
    end

    // State, counter, TREADY and LFSR registers; a config load restarts the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= init_state(POL_OSC);
            cnt    <= '0;
            tready <= 1'b0;
            lfsr   <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_nxt;
            if (restart) begin
                state  <= init_state(pol);
                cnt    <= '0;
                tready <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                tready <= tready_nxt;
            end
        end
    end

endmodule

// File: rtl/axi4_stream_sink.sv
// AXI4-Stream sink: latches the back-pressure configuration, drives TREADY via
// axi4_stream_ready_gen and accumulates beat/byte/packet counts plus a
// per-packet XOR checksum. Defining AXI4_STREAM_SINK_PROTOCOL_CHECK_EN adds
// sts_proto_err, counting cycles where a stalled beat was dropped or changed.
module axi4_stream_sink
    import axi4_stream_sink_pkg::*;
#(
    parameter int DN = 1,
    parameter int DW = 8 * DN,
    parameter int CW = 16,
    parameter int SW = 32
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic          TVALID,
    output logic          TREADY,
    input  logic [DW-1:0] TDATA,
    input  logic [DN-1:0] TKEEP,
    input  logic          TLAST,
    input  logic          cfg_load,
    input  logic [2:0]    cfg_policy,
    input  logic [CW-1:0] cfg_low,
    input  logic [CW-1:0] cfg_high,
    input  logic [CW-1:0] cfg_events,
    output logic [SW-1:0] sts_beats,
    output logic [SW-1:0] sts_bytes,
    output logic [SW-1:0] sts_pkts,
    output logic [DW-1:0] pkt_chk,
    output logic          pkt_chk_vld
`ifdef AXI4_STREAM_SINK_PROTOCOL_CHECK_EN
    ,
    output logic [SW-1:0] sts_proto_err
`endif
);

    logic [2:0]    lat_policy, eff_policy;
    logic [CW-1:0] lat_low, lat_high, lat_events;
    logic [CW-1:0] eff_low, eff_high, eff_events;
    logic [DW-1:0] run_xor;
    logic          handshake;

    assign handshake = TVALID & TREADY;

    // During the load cycle the ready generator restarts from the incoming
    // configuration, so it sees the new values one cycle before they latch.
    assign eff_policy = cfg_load ? cfg_policy : lat_policy;
    assign eff_low    = cfg_load ? cfg_low    : lat_low;
    assign eff_high   = cfg_load ? cfg_high   : lat_high;
    assign eff_events = cfg_load ? cfg_events : lat_events;

    // Configuration latch.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            lat_policy <= POL_OSC;
            lat_low    <= CW'(0);
            lat_high   <= CW'(1);
            lat_events <= CW'(1);
        end else if (cfg_load) begin
            lat_policy <= cfg_policy;
            lat_low    <= cfg_low;
            lat_high   <= cfg_high;
            lat_events <= cfg_events;
        end
    end

    axi4_stream_ready_gen #(
        .CW(CW)
    ) u_ready_gen (
        .clk       (ACLK),
        .rst       (ARESET),
        .restart   (cfg_load),
        .tvalid    (TVALID),
        .handshake (handshake),
        .policy    (eff_policy),
        .low       (eff_low),
        .high      (eff_high),
        .events    (eff_events),
        .tready    (TREADY)
    );

    // Statistics and checksum; every handshake counts, including in a load cycle.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sts_beats   <= '0;
            sts_bytes   <= '0;
            sts_pkts    <= '0;
            pkt_chk     <= '0;
            pkt_chk_vld <= 1'b0;
            run_xor     <= '0;
        end else begin
            pkt_chk_vld <= handshake & TLAST;
            if (handshake) begin
                sts_beats <= sts_beats + SW'(1);
                sts_bytes <= sts_bytes + SW'(popcount(128'(TKEEP)));
                if (TLAST) begin
                    sts_pkts <= sts_pkts + SW'(1);
                    pkt_chk  <= run_xor ^ TDATA;
                    run_xor  <= '0;
                end else begin
                    run_xor <= run_xor ^ TDATA;
                end
            end
        end
    end

`ifdef AXI4_STREAM_SINK_PROTOCOL_CHECK_EN
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DN-1:0] prev_keep;
    logic          prev_last;
    logic          proto_hit;

    assign proto_hit = prev_stall & (~TVALID | (TDATA != prev_data) |
                                     (TKEEP != prev_keep) | (TLAST != prev_last));

    // A stalled beat must stay valid and unchanged until it is accepted.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            prev_stall    <= 1'b0;
            prev_data     <= '0;
            prev_keep     <= '0;
            prev_last     <= 1'b0;
            sts_proto_err <= '0;
        end else begin
            prev_stall <= TVALID & ~TREADY;
            prev_data  <= TDATA;
            prev_keep  <= TKEEP;
            prev_last  <= TLAST;
            if (proto_hit) begin
                sts_proto_err <= sts_proto_err + SW'(1);
            end
        end
    end
`endif

endmodule
